// File: rtl/dnu_iter_sequencer.sv
// Iteration sequencer feeding the per-bank DNU write FSMs: issues iter_rqst, forces
// termination on early stop or watchdog expiry, counts iterations. Optional ITER_CYCLE_CNT_EN adds cycle_cnt.
module dnu_iter_sequencer #(
  parameter int NUM_UNITS      = 4,
  parameter int MAX_ITER       = 10,
  parameter int ITER_WIDTH     = $clog2(MAX_ITER+1),
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                   write_clk,
  input  logic                   rst,
  input  logic                   decode_start,
  input  logic                   early_stop,
  input  logic [2*NUM_UNITS-1:0] unit_busy,
  output logic                   iter_rqst,
  output logic                   iter_termination,
  output logic [ITER_WIDTH-1:0]  iter_cnt,
  output logic                   decode_busy,
  output logic                   decode_done,
  output logic                   timeout_err,
  output logic [2:0]             state
`ifdef ITER_CYCLE_CNT_EN
  ,
  output logic [15:0]            cycle_cnt
`endif
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE      = 3'b000,
    WAIT_IDLE = 3'b001,
    RQST      = 3'b010,
    RELEASE   = 3'b011,
    CHECK     = 3'b100,
    DONE      = 3'b101
  } state_e;

  state_e              state_q, state_d;
  logic                iter_rqst_q, iter_rqst_d;
  logic                term_q, term_d;
  logic                terminated_q, terminated_d;
  logic [ITER_WIDTH-1:0] iter_cnt_q, iter_cnt_d;
  logic                decode_busy_q, decode_busy_d;
  logic                timeout_err_q, timeout_err_d;
  logic [WD_W-1:0]     watchdog_q, watchdog_d;
  logic                all_fin, all_idle, wd_expired, at_max;
`ifdef ITER_CYCLE_CNT_EN
  logic [15:0]         cycle_cnt_q, cycle_cnt_d;
`endif

  // A 2'b11 slice counts as neither idle nor finished, so it stalls both waits.
  always_comb begin
    all_fin  = 1'b1;
    all_idle = 1'b1;
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (unit_busy[2*k +: 2] != 2'b10) all_fin  = 1'b0;
      if (unit_busy[2*k +: 2] != 2'b00) all_idle = 1'b0;
    end
  end

  assign wd_expired = (watchdog_q == WD_W'(TIMEOUT_CYCLES-1));
  assign at_max     = (iter_cnt_q == ITER_WIDTH'(MAX_ITER));

  always_ff @(posedge write_clk) begin
    if (rst) begin
      state_q       <= IDLE;
      iter_rqst_q   <= 1'b0;
      term_q        <= 1'b0;
      terminated_q  <= 1'b0;
      iter_cnt_q    <= '0;
      decode_busy_q <= 1'b0;
      timeout_err_q <= 1'b0;
      watchdog_q    <= '0;
`ifdef ITER_CYCLE_CNT_EN
      cycle_cnt_q   <= '0;
`endif
    end else begin
      state_q       <= state_d;
      iter_rqst_q   <= iter_rqst_d;
      term_q        <= term_d;
      terminated_q  <= terminated_d;
      iter_cnt_q    <= iter_cnt_d;
      decode_busy_q <= decode_busy_d;
      timeout_err_q <= timeout_err_d;
      watchdog_q    <= watchdog_d;
`ifdef ITER_CYCLE_CNT_EN
      cycle_cnt_q   <= cycle_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (decode_start) state_d = WAIT_IDLE;
      WAIT_IDLE: if (all_idle)     state_d = RQST;
      RQST:      if (all_fin)      state_d = RELEASE;
      RELEASE:   if (all_idle)     state_d = CHECK;
      CHECK:     state_d = (terminated_q || early_stop || at_max) ? DONE : WAIT_IDLE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs; iter_rqst tracks the next state so it is high exactly in RQST.
  always_comb begin
    iter_cnt_d    = iter_cnt_q;
    watchdog_d    = watchdog_q;
    term_d        = term_q;
    terminated_d  = terminated_q;
    timeout_err_d = timeout_err_q;
    decode_busy_d = decode_busy_q;
    iter_rqst_d   = (state_d == RQST);
`ifdef ITER_CYCLE_CNT_EN
    cycle_cnt_d   = (decode_busy_q && cycle_cnt_q != 16'hFFFF) ? cycle_cnt_q + 16'd1 : cycle_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (decode_start) begin
          iter_cnt_d    = '0;
          timeout_err_d = 1'b0;
          decode_busy_d = 1'b1;
`ifdef ITER_CYCLE_CNT_EN
          cycle_cnt_d   = '0;
`endif
        end
      end
      RQST: begin
        watchdog_d = wd_expired ? watchdog_q : watchdog_q + 1'b1;
        if (early_stop || wd_expired) begin
          term_d       = 1'b1;
          terminated_d = 1'b1;
        end
        if (wd_expired) timeout_err_d = 1'b1;
        if (all_fin) watchdog_d = '0;
      end
      RELEASE: begin
        if (all_idle) begin
          term_d     = 1'b0;
          iter_cnt_d = at_max ? iter_cnt_q : iter_cnt_q + 1'b1;
        end
      end
      CHECK:   terminated_d  = 1'b0;
      DONE:    decode_busy_d = 1'b0;
      default: ;
    endcase
  end

  assign iter_rqst        = iter_rqst_q;
  assign iter_termination = term_q;
  assign iter_cnt         = iter_cnt_q;
  assign decode_busy      = decode_busy_q;
  assign decode_done      = (state_q == DONE);
  assign timeout_err      = timeout_err_q;
  assign state            = state_q;
`ifdef ITER_CYCLE_CNT_EN
  assign cycle_cnt        = cycle_cnt_q;
`endif

endmodule
